// File: rtl/tff_counter_pkg.sv
// tff_counter_pkg: direction constants and binary-to-Gray helper shared by the counter slice
package tff_counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/tff_counter_if.sv
// tff_counter_if: control/data bundle of the counter; q_gray present only with TFF_COUNTER_GRAY_EN
interface tff_counter_if #(parameter int WIDTH = 8);
  logic clear;
  logic load;
  logic [WIDTH-1:0] din;
  logic en;
  logic up;
  logic [WIDTH-1:0] q;
  logic tc;
  logic wrap;
`ifdef TFF_COUNTER_GRAY_EN
  logic [WIDTH-1:0] q_gray;
  modport master(output clear, load, din, en, up, input q, tc, wrap, q_gray);
  modport slave(input clear, load, din, en, up, output q, tc, wrap, q_gray);
`else
  modport master(output clear, load, din, en, up, input q, tc, wrap);
  modport slave(input clear, load, din, en, up, output q, tc, wrap);
`endif
endinterface

// File: rtl/tff_cell.sv
// tff_cell: 1-bit T flip-flop with asynchronous active-low reset to 0
module tff_cell (
  input  logic t,
  input  logic clk,
  input  logic reset,
  output logic q
);
  // toggle on t, cleared immediately by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= 1'b0;
    else q <= q ^ t;
endmodule

// File: rtl/tff_counter.sv
// tff_counter: modulo-(MAX+1) up/down counter built from T flip-flops; optional Gray output via TFF_COUNTER_GRAY_EN
module tff_counter
  import tff_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX = {WIDTH{1'b1}},
  parameter int SATURATE = 0
) (
  input logic clk,
  input logic reset,
  tff_counter_if.slave bus
);
  localparam bit SAT = SATURATE != 0;
  logic [WIDTH-1:0] q, q_next, t;
  logic at_lim, wrap_next, wrap;
  // next count from clear > load > en priority; at_lim marks the terminal value for the current direction
  always_comb begin
    at_lim = (bus.up == DIR_UP && q == MAX) || (bus.up == DIR_DOWN && q == '0);
    q_next = bus.clear ? '0
           : bus.load ? (bus.din > MAX ? MAX : bus.din)
           : !bus.en ? q
           : at_lim ? (SAT ? q : (bus.up == DIR_UP ? '0 : MAX))
           : bus.up == DIR_UP ? q + WIDTH'(1) : q - WIDTH'(1);
    wrap_next = !bus.clear && !bus.load && bus.en && at_lim && !SAT;
  end
  assign t = q ^ q_next;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_cell (.t(t[i]), .clk(clk), .reset(reset), .q(q[i]));
  end
  // one-cycle pulse after a modular rollover
  always_ff @(posedge clk or negedge reset)
    if (!reset) wrap <= 1'b0;
    else wrap <= wrap_next;
  assign bus.q = q;
  assign bus.tc = at_lim;
  assign bus.wrap = wrap;
`ifdef TFF_COUNTER_GRAY_EN
  logic [WIDTH-1:0] gray;
  // Gray image of the next count, registered alongside the cells
  always_ff @(posedge clk or negedge reset)
    if (!reset) gray <= '0;
    else gray <= WIDTH'(bin2gray(32'(q_next)));
  assign bus.q_gray = gray;
`endif
endmodule

// File: tb/tb_tff_counter.sv
// tb_tff_counter: wrap/saturate/full-range counters driven in lockstep, checked against tables and an arithmetic model
module tb_tff_counter;
  logic clk = 1'b0, reset = 1'b0;
  logic clear = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1;
  logic [3:0] din = '0;
  int nchk = 0, nerr = 0;
  int mq[3], mw[3];
  int mx[3] = '{9, 9, 15};
  bit sat[3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  tff_counter_if #(.WIDTH(4)) i0 ();
  tff_counter_if #(.WIDTH(4)) i1 ();
  tff_counter_if #(.WIDTH(4)) i2 ();
  assign {i0.clear, i0.load, i0.en, i0.up, i0.din} = {clear, load, en, up, din};
  assign {i1.clear, i1.load, i1.en, i1.up, i1.din} = {clear, load, en, up, din};
  assign {i2.clear, i2.load, i2.en, i2.up, i2.din} = {clear, load, en, up, din};
  tff_counter #(.WIDTH(4), .MAX(4'd9), .SATURATE(0)) d0 (.clk(clk), .reset(reset), .bus(i0.slave));
  tff_counter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1)) d1 (.clk(clk), .reset(reset), .bus(i1.slave));
  tff_counter #(.WIDTH(4), .MAX(4'd15), .SATURATE(0)) d2 (.clk(clk), .reset(reset), .bus(i2.slave));

  typedef struct {
    bit c, l, e, u;
    int d;
    int q0, w0, tc0, q1, w1, tc1;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic int tcm(int k);
    return up ? int'(mq[k] == mx[k]) : int'(mq[k] == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0;
      mw[k] = 0;
    end
  endtask

  task automatic step(input bit c, input bit l, input bit e, input bit u, input int d);
    clear = c; load = l; en = e; up = u; din = 4'(d);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int m = mx[k], q = mq[k], nq = q, nw = 0;
      if (c) nq = 0;
      else if (l) nq = d > m ? m : d;
      else if (e && u) begin
        nq = sat[k] ? (q < m ? q + 1 : m) : (q + 1) % (m + 1);
        nw = int'(!sat[k] && q == m);
      end else if (e) begin
        nq = sat[k] ? (q > 0 ? q - 1 : 0) : (q + m) % (m + 1);
        nw = int'(!sat[k] && q == 0);
      end
      mq[k] = nq;
      mw[k] = nw;
    end
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("q0", i0.q, mq[0]); chk("wrap0", i0.wrap, mw[0]); chk("tc0", i0.tc, tcm(0));
    chk("q1", i1.q, mq[1]); chk("wrap1", i1.wrap, mw[1]); chk("tc1", i1.tc, tcm(1));
    chk("q2", i2.q, mq[2]); chk("wrap2", i2.wrap, mw[2]); chk("tc2", i2.tc, tcm(2));
`ifdef TFF_COUNTER_GRAY_EN
    chk("gray2", i2.q_gray, mq[2] ^ (mq[2] >> 1));
`endif
  endtask

  initial begin
    vec_t tbl[24];
    for (int i = 0; i < 8; i++) tbl[i] = '{0, 0, 1, 1, 0, i + 1, 0, 0, i + 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 1, 0, 9, 0, 1, 9, 0, 1};
    tbl[9]  = '{0, 0, 1, 1, 0, 0, 1, 0, 9, 0, 1};
    tbl[10] = '{0, 0, 1, 1, 0, 1, 0, 0, 9, 0, 1};
    tbl[11] = '{0, 0, 1, 1, 0, 2, 0, 0, 9, 0, 1};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[13] = '{0, 0, 1, 0, 0, 9, 1, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 1, 0, 0, 8, 0, 0, 0, 0, 1};
    tbl[15] = '{0, 0, 1, 1, 0, 9, 0, 1, 1, 0, 0};
    tbl[16] = '{0, 1, 0, 1, 8, 8, 0, 0, 8, 0, 0};
    tbl[17] = '{0, 0, 1, 1, 0, 9, 0, 1, 9, 0, 1};
    tbl[18] = '{0, 0, 1, 1, 0, 0, 1, 0, 9, 0, 1};
    tbl[19] = '{0, 0, 1, 1, 0, 1, 0, 0, 9, 0, 1};
    tbl[20] = '{0, 1, 0, 1, 15, 9, 0, 1, 9, 0, 1};
    tbl[21] = '{1, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0};
    tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[23] = '{0, 1, 0, 1, 5, 5, 0, 0, 5, 0, 0};
    model_reset();
    #1;
    chk("rst_q", i0.q, 0); chk("rst_wrap", i0.wrap, 0); chk("rst_tc_up", i0.tc, 0);
    up = 1'b0;
    #1;
    chk("rst_tc_down", i0.tc, 1);
    @(negedge clk);
    reset = 1'b1;
    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].d);
      chk($sformatf("tbl%0d_q0", i), i0.q, tbl[i].q0);
      chk($sformatf("tbl%0d_w0", i), i0.wrap, tbl[i].w0);
      chk($sformatf("tbl%0d_tc0", i), i0.tc, tbl[i].tc0);
      chk($sformatf("tbl%0d_q1", i), i1.q, tbl[i].q1);
      chk($sformatf("tbl%0d_w1", i), i1.wrap, tbl[i].w1);
      chk($sformatf("tbl%0d_tc1", i), i1.tc, tbl[i].tc1);
      check_model();
    end
    #2 reset = 1'b0;
    #1;
    chk("async_q0", i0.q, 0); chk("async_w0", i0.wrap, 0); chk("async_q1", i1.q, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 1, 1, 0);
    chk("resume1", i0.q, 1);
    step(0, 0, 1, 1, 0);
    chk("resume2", i0.q, 2);
    check_model();
    step(0, 1, 0, 1, 9);
    step(0, 0, 1, 1, 0);
    chk("pre_rst_wrap", i0.wrap, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_kills_wrap", i0.wrap, 0); chk("rst_kills_q", i0.q, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      check_model();
    end
`ifdef TFF_COUNTER_GRAY_EN
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      logic [3:0] prev = i2.q_gray;
      step(0, 0, 1, 1, 0);
      chk("gray_one_bit", $countones(i2.q_gray ^ prev), 1);
    end
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/tff_counter.md
TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits, legal range 2..32.
REQ-002 Parameter MAX, default 2**WIDTH-1, highest count value (modulus MAX+1), legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port clear  input  1  synchronous clear to 0.
REQ-007 Port load  input  1  synchronous parallel load of din.
REQ-008 Port din  input  WIDTH  load value.
REQ-009 Port en  input  1  count enable.
REQ-010 Port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-011 Port q  output  WIDTH  registered count.
REQ-012 Port tc  output  1  terminal count, combinational: (up && q==MAX) || (!up && q==0).
REQ-013 Port wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap occurred.

Function
REQ-014 Each bit of q SHALL be held in a T flip-flop; the next state SHALL be formed by driving toggle vector t = q XOR q_next, with no direct D path.
REQ-015 Priority per rising edge: clear > load > en; with all three low, q holds and wrap = 0.
REQ-016 clear=1: q <= 0, wrap <= 0, regardless of load/en/up.
REQ-017 load=1: q <= din if din <= MAX, else q <= MAX; wrap <= 0.
REQ-018 en=1, up=1, q<MAX: q <= q+1; en=1, up=0, q>0: q <= q-1; wrap <= 0.
REQ-019 en=1, up=1, q==MAX: SATURATE=0 -> q <= 0, wrap <= 1; SATURATE=1 -> q holds, wrap <= 0.
REQ-020 en=1, up=0, q==0: SATURATE=0 -> q <= MAX, wrap <= 1; SATURATE=1 -> q holds, wrap <= 0.
REQ-021 Latency: q reflects a clear/load/count one clock after the sampling edge; tc follows q and up with zero cycles.
REQ-022 Changing up between cycles SHALL take effect on the next edge with no dead cycle.
REQ-023 q SHALL never hold a value greater than MAX.

Reset
REQ-024 reset low SHALL immediately force q = 0 and wrap = 0, independent of clk.
REQ-025 Reset asserted mid-count SHALL abort the count; release SHALL be followed by normal operation from q = 0 on the first rising edge with reset high.
REQ-026 tc after reset SHALL equal !up (q==0 is terminal for down-counting).

Configuration
REQ-027 Macro TFF_COUNTER_GRAY_EN defined: adds output q_gray [WIDTH] = registered Gray code of q (q_next ^ (q_next>>1)), updated on the same edge as q and reset to 0.
REQ-028 Macro not defined: no q_gray port and no Gray register; all other behaviour identical.

Structure
REQ-029 Package tff_counter_pkg SHALL hold the direction constants (DIR_UP=1, DIR_DOWN=0) and the binary-to-Gray conversion function.
REQ-030 Sub-module tff_cell (1-bit T flip-flop: t, clk, reset, q; async active-low reset to 0) SHALL be instantiated WIDTH times via generate.

Verification
REQ-031 WIDTH=4, MAX=9, SATURATE=0: reset, en=1, up=1 for 12 cycles -> q: 1..9, 0, 1, 2; wrap high exactly in the cycle after 9->0.
REQ-032 Same config, up=0 from q=0 -> q becomes 9, wrap pulses once; tc=1 while q==0 and up=0.
REQ-033 SATURATE=1, MAX=9: load din=8, count up 3 cycles -> q: 9, 9, 9; wrap never asserts; tc=1.
REQ-034 load din=15 with MAX=9 -> q=9; clear, load, en all high in one cycle -> q=0.
REQ-035 Assert reset low asynchronously mid-cycle at q=5 -> q=0 and wrap=0 before the next edge; release -> counting resumes 1, 2.
REQ-036 With TFF_COUNTER_GRAY_EN, WIDTH=4 free-running up -> consecutive q_gray values differ in exactly one bit, including the 15->0 wrap.
